// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-port data-memory arbiter: state encoding,
// default geometry and the width of the lock-timeout counter.
package dmem_arb_pkg;

    // Default data-memory address width (words)
    localparam int AWL_DEFAULT = 6;
    // Default data-memory word width
    localparam int DWL_DEFAULT = 32;
    // Default number of idle owner cycles before a lock is released
    localparam int TMO_DEFAULT = 4;
    // The lock timer is four bits wide, which bounds TMO to 1..15
    localparam int TMR_W = 4;

    // IDLE: nobody owns the memory, OWN0/OWN1: requester 0/1 holds a lock
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    // Lock state that corresponds to a given requester index
    function automatic arb_state_t own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/arb_lock_timer.sv
// Lock timeout counter: counts owner-idle cycles and flags the cycle on which
// the count reaches TMO so the arbiter can drop the lock.
module arb_lock_timer
    import dmem_arb_pkg::*;
#(
    parameter int TMO = TMO_DEFAULT
)
(
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TMO);

    logic [TMR_W-1:0] count_q;

    // The idle cycle being counted now is the TMO-th one, so the lock ends here
    always_comb begin
        expire = count_en && (count_q == (LIMIT - 1'b1));
    end

    // Count owner-idle cycles; any accepted access, expiry or leaving a lock restarts it
    always_ff @(posedge CLK) begin
        if (RST || clear || expire) begin
            count_q <= '0;
        end else if (count_en) begin
            count_q <= count_q + 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of an external single-port data memory.
// Alternating priority when both request, optional ownership locks with an
// idle timeout, and registered per-requester read responses.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AWL = AWL_DEFAULT,
    parameter int DWL = DWL_DEFAULT,
    parameter int TMO = TMO_DEFAULT
)
(
    input  logic           CLK,
    input  logic           RST,
    input  logic           REQ0,
    input  logic           WE0,
    input  logic           LOCK0,
    input  logic [AWL-1:0] ADDR0,
    input  logic [DWL-1:0] WDATA0,
    input  logic           REQ1,
    input  logic           WE1,
    input  logic           LOCK1,
    input  logic [AWL-1:0] ADDR1,
    input  logic [DWL-1:0] WDATA1,
    output logic           GNT0,
    output logic           GNT1,
    output logic           RVALID0,
    output logic           RVALID1,
    output logic [DWL-1:0] RDATA0,
    output logic [DWL-1:0] RDATA1,
    output logic           DMWE,
    output logic [AWL-1:0] DMWA,
    output logic [DWL-1:0] DMWD,
    input  logic [DWL-1:0] DMRD
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       pri_q;
    logic       pri_d;

    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] lock;
    logic [1:0] gnt;
    logic       accepted;
    logic       sel;
    logic       tmr_clear;
    logic       tmr_count_en;
    logic       tmr_expire;

    assign req  = {REQ1, REQ0};
    assign we   = {WE1, WE0};
    assign lock = {LOCK1, LOCK0};

    assign GNT0     = gnt[0];
    assign GNT1     = gnt[1];
    assign accepted = |gnt;
    assign sel      = gnt[1];

    // Grant decision: free arbitration in IDLE, only the owner while locked, nothing during reset
    always_comb begin
        gnt = 2'b00;
        if (!RST) begin
            case (state_q)
                IDLE: begin
                    if (req == 2'b11) begin
                        gnt = pri_q ? 2'b10 : 2'b01;
                    end else begin
                        gnt = req;
                    end
                end
                OWN0:    gnt = {1'b0, req[0]};
                OWN1:    gnt = {req[1], 1'b0};
                default: gnt = 2'b00;
            endcase
        end
    end

    // The timer only runs while an owner holds the lock without requesting
    always_comb begin
        tmr_count_en = ((state_q == OWN0) && !REQ0) || ((state_q == OWN1) && !REQ1);
        tmr_clear    = accepted || (state_q == IDLE);
    end

    arb_lock_timer #(
        .TMO(TMO)
    ) u_lock_timer (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (tmr_clear),
        .count_en (tmr_count_en),
        .expire   (tmr_expire)
    );

    // Next state and priority: an access flips priority and sets/clears the lock, expiry unlocks
    always_comb begin
        state_d = state_q;
        pri_d   = pri_q;
        if (accepted) begin
            pri_d = ~sel;
            if (lock[sel]) begin
                state_d = own_state(sel);
            end else begin
                state_d = IDLE;
            end
        end else if (tmr_expire) begin
            state_d = IDLE;
        end
    end

    // State and priority registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pri_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
        end
    end

    // Memory port carries the granted requester's access, and is all zero otherwise
    always_comb begin
        DMWE = 1'b0;
        DMWA = '0;
        DMWD = '0;
        if (accepted) begin
            DMWE = we[sel];
            DMWA = sel ? ADDR1 : ADDR0;
            DMWD = sel ? WDATA1 : WDATA0;
        end
    end

    // Read responses: one-cycle strobe, data captured from memory at acceptance and held after
    always_ff @(posedge CLK) begin
        if (RST) begin
            RVALID0 <= 1'b0;
            RVALID1 <= 1'b0;
            RDATA0  <= '0;
            RDATA1  <= '0;
        end else begin
            RVALID0 <= gnt[0] && !WE0;
            RVALID1 <= gnt[1] && !WE1;
            if (gnt[0] && !WE0) begin
                RDATA0 <= DMRD;
            end
            if (gnt[1] && !WE1) begin
                RDATA1 <= DMRD;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a behavioural arbitration model and a response scoreboard.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int AWL   = AWL_DEFAULT;
    localparam int DWL   = DWL_DEFAULT;
    localparam int TMO   = TMO_DEFAULT;
    localparam int DEPTH = 1 << AWL;

    logic           CLK = 1'b0;
    logic           RST;
    logic           REQ0, WE0, LOCK0, REQ1, WE1, LOCK1;
    logic [AWL-1:0] ADDR0, ADDR1;
    logic [DWL-1:0] WDATA0, WDATA1;
    logic           GNT0, GNT1, RVALID0, RVALID1;
    logic [DWL-1:0] RDATA0, RDATA1;
    logic           DMWE;
    logic [AWL-1:0] DMWA;
    logic [DWL-1:0] DMWD;
    logic [DWL-1:0] DMRD;

    logic [DWL-1:0] dut_mem [DEPTH];
    logic [DWL-1:0] ref_mem [DEPTH];

    typedef struct {
        int             due;
        logic [DWL-1:0] data;
    } resp_t;

    resp_t exp_q0[$];
    resp_t exp_q1[$];

    int cyc         = 0;
    int check_count = 0;
    int fail_count  = 0;

    int owner  = -1;
    int pri_m  = 0;
    int idle_m = 0;

    logic [DWL-1:0] last_rdata0 = '0;
    logic [DWL-1:0] last_rdata1 = '0;

    dmem_arbiter #(
        .AWL(AWL),
        .DWL(DWL),
        .TMO(TMO)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .REQ0    (REQ0),
        .WE0     (WE0),
        .LOCK0   (LOCK0),
        .ADDR0   (ADDR0),
        .WDATA0  (WDATA0),
        .REQ1    (REQ1),
        .WE1     (WE1),
        .LOCK1   (LOCK1),
        .ADDR1   (ADDR1),
        .WDATA1  (WDATA1),
        .GNT0    (GNT0),
        .GNT1    (GNT1),
        .RVALID0 (RVALID0),
        .RVALID1 (RVALID1),
        .RDATA0  (RDATA0),
        .RDATA1  (RDATA1),
        .DMWE    (DMWE),
        .DMWA    (DMWA),
        .DMWD    (DMWD),
        .DMRD    (DMRD)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc++;

    // External memory seen by the DUT
    always @(posedge CLK) begin
        if (DMWE) dut_mem[DMWA] <= DMWD;
    end
    assign DMRD = dut_mem[DMWA];

    function automatic logic [DWL-1:0] init_word(input int i);
        return 32'h1000_0000 + 32'(i * 257);
    endfunction

    task automatic checkOutput(input string name, input logic [DWL-1:0] actual,
                               input logic [DWL-1:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit rst,
                                 input bit r0, input bit w0, input bit l0,
                                 input logic [AWL-1:0] a0, input logic [DWL-1:0] d0,
                                 input bit r1, input bit w1, input bit l1,
                                 input logic [AWL-1:0] a1, input logic [DWL-1:0] d1);
        @(posedge CLK);
        #1;
        RST = rst;
        REQ0 = r0; WE0 = w0; LOCK0 = l0; ADDR0 = a0; WDATA0 = d0;
        REQ1 = r1; WE1 = w1; LOCK1 = l1; ADDR1 = a1; WDATA1 = d1;
        @(negedge CLK);
    endtask

    // Reference model: who may use the memory this cycle, what the port must show,
    // and which read responses are owed next cycle
    always @(negedge CLK) begin : model
        int             g;
        bit [1:0]       reqv, wev, lockv;
        logic [AWL-1:0] addrv [2];
        logic [DWL-1:0] wdv [2];
        resp_t          resp;

        reqv  = {REQ1, REQ0};
        wev   = {WE1, WE0};
        lockv = {LOCK1, LOCK0};
        addrv[0] = ADDR0; addrv[1] = ADDR1;
        wdv[0]   = WDATA0; wdv[1]  = WDATA1;

        g = -1;
        if (!RST) begin
            if (owner < 0) begin
                if (reqv == 2'b11)  g = pri_m;
                else if (reqv[0])   g = 0;
                else if (reqv[1])   g = 1;
            end else if (reqv[owner]) begin
                g = owner;
            end
        end

        checkOutput("gnt0", GNT0, (g == 0));
        checkOutput("gnt1", GNT1, (g == 1));
        checkOutput("dmwe", DMWE, (g >= 0) ? wev[g] : 1'b0);
        checkOutput("dmwa", DMWA, (g >= 0) ? addrv[g] : '0);
        checkOutput("dmwd", DMWD, (g >= 0) ? wdv[g] : '0);

        if (RST) begin
            owner  = -1;
            pri_m  = 0;
            idle_m = 0;
        end else if (g >= 0) begin
            pri_m  = 1 - g;
            idle_m = 0;
            if (wev[g]) begin
                ref_mem[addrv[g]] = wdv[g];
            end else begin
                resp.due  = cyc + 1;
                resp.data = ref_mem[addrv[g]];
                if (g == 0) exp_q0.push_back(resp);
                else        exp_q1.push_back(resp);
            end
            owner = lockv[g] ? g : -1;
        end else if (owner >= 0) begin
            idle_m++;
            if (idle_m >= TMO) begin
                owner  = -1;
                idle_m = 0;
            end
        end
    end

    // Monitor: pops expected responses when they are due and checks held read data
    always @(negedge CLK) begin : monitor
        resp_t r;
        bit    due0, due1;

        due0 = (exp_q0.size() > 0) && (exp_q0[0].due == cyc);
        due1 = (exp_q1.size() > 0) && (exp_q1[0].due == cyc);
        checkOutput("rvalid0", RVALID0, due0);
        checkOutput("rvalid1", RVALID1, due1);
        if (due0) begin
            r = exp_q0.pop_front();
            last_rdata0 = r.data;
        end
        if (due1) begin
            r = exp_q1.pop_front();
            last_rdata1 = r.data;
        end
        checkOutput("rdata0", RDATA0, last_rdata0);
        checkOutput("rdata1", RDATA1, last_rdata1);
        if (RST) begin
            last_rdata0 = '0;
            last_rdata1 = '0;
            exp_q0.delete();
            exp_q1.delete();
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            dut_mem[i] = init_word(i);
            ref_mem[i] = init_word(i);
        end
        RST = 1'b1;
        REQ0 = 1'b1; WE0 = 1'b0; LOCK0 = 1'b0; ADDR0 = '0; WDATA0 = '0;
        REQ1 = 1'b1; WE1 = 1'b0; LOCK1 = 1'b0; ADDR1 = '0; WDATA1 = '0;

        // Reset with both requesting: no grants, no writes
        applyStimulus(1, 1, 1, 0, AWL'(1), 32'h1111, 1, 1, 0, AWL'(2), 32'h2222);
        applyStimulus(1, 1, 1, 0, AWL'(1), 32'h1111, 1, 1, 0, AWL'(2), 32'h2222);
        checkOutput("reset_gnt0", GNT0, 1'b0);
        checkOutput("reset_dmwe", DMWE, 1'b0);

        // Both reading: grants alternate starting with requester 0
        applyStimulus(0, 1, 0, 0, AWL'(3), '0, 1, 0, 0, AWL'(5), '0);
        checkOutput("alt_c1_gnt0", GNT0, 1'b1);
        applyStimulus(0, 1, 0, 0, AWL'(3), '0, 1, 0, 0, AWL'(5), '0);
        checkOutput("alt_c2_gnt1", GNT1, 1'b1);
        checkOutput("alt_c2_rdata0", RDATA0, init_word(3));
        applyStimulus(0, 1, 0, 0, AWL'(3), '0, 1, 0, 0, AWL'(5), '0);
        checkOutput("alt_c3_gnt0", GNT0, 1'b1);
        checkOutput("alt_c3_rdata1", RDATA1, init_word(5));
        applyStimulus(0, 1, 0, 0, AWL'(3), '0, 1, 0, 0, AWL'(5), '0);
        checkOutput("alt_c4_gnt1", GNT1, 1'b1);

        // Write by requester 1 then read back by requester 0 the next cycle
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 1, 0, AWL'(7), 32'hDEADBEEF);
        checkOutput("wr_dmwe", DMWE, 1'b1);
        checkOutput("wr_dmwd", DMWD, 32'hDEADBEEF);
        applyStimulus(0, 1, 0, 0, AWL'(7), '0, 0, 0, 0, '0, '0);
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput("rb_rvalid0", RVALID0, 1'b1);
        checkOutput("rb_rdata0", RDATA0, 32'hDEADBEEF);
        applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        checkOutput("rb_rvalid0_once", RVALID0, 1'b0);

        // Locked read-modify-write by requester 0 holds requester 1 off
        applyStimulus(0, 1, 0, 1, AWL'(9), '0, 0, 0, 0, '0, '0);
        checkOutput("rmw_rd_gnt0", GNT0, 1'b1);
        applyStimulus(0, 0, 0, 1, AWL'(9), '0, 1, 0, 0, AWL'(2), '0);
        checkOutput("rmw_gap_gnt1", GNT1, 1'b0);
        applyStimulus(0, 1, 1, 0, AWL'(9), init_word(9) + 1, 1, 0, 0, AWL'(2), '0);
        checkOutput("rmw_wr_gnt0", GNT0, 1'b1);
        checkOutput("rmw_wr_gnt1", GNT1, 1'b0);
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 0, AWL'(9), '0);
        checkOutput("rmw_after_gnt1", GNT1, 1'b1);

        // Requester 1 locks then goes quiet: requester 0 waits exactly TMO cycles
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 1, AWL'(4), '0);
        checkOutput("tmo_lock_gnt1", GNT1, 1'b1);
        for (int i = 0; i < TMO; i++) begin
            applyStimulus(0, 1, 0, 0, AWL'(4), '0, 0, 0, 0, '0, '0);
            checkOutput("tmo_wait_gnt0", GNT0, 1'b0);
        end
        applyStimulus(0, 1, 0, 0, AWL'(4), '0, 0, 0, 0, '0, '0);
        checkOutput("tmo_expire_gnt0", GNT0, 1'b1);

        // Reset while requester 0 owns the memory with a read in flight
        applyStimulus(0, 1, 0, 1, AWL'(3), '0, 0, 0, 0, '0, '0);
        applyStimulus(0, 1, 0, 1, AWL'(5), '0, 1, 0, 0, AWL'(6), '0);
        checkOutput("own_rd_gnt0", GNT0, 1'b1);
        applyStimulus(1, 1, 0, 1, AWL'(5), '0, 1, 0, 0, AWL'(6), '0);
        checkOutput("rst_own_gnt0", GNT0, 1'b0);
        applyStimulus(0, 0, 0, 0, '0, '0, 1, 0, 0, AWL'(6), '0);
        checkOutput("post_rst_rvalid0", RVALID0, 1'b0);
        checkOutput("post_rst_rdata0", RDATA0, '0);
        checkOutput("post_rst_gnt1", GNT1, 1'b1);

        // Priority returns to requester 0 after reset
        applyStimulus(0, 1, 0, 0, AWL'(8), '0, 0, 0, 0, '0, '0);
        applyStimulus(1, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        applyStimulus(0, 1, 0, 0, AWL'(8), '0, 1, 0, 0, AWL'(9), '0);
        checkOutput("post_rst_pri_gnt0", GNT0, 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), AWL'($urandom_range(0, 15)), $urandom,
                          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 3) == 0), AWL'($urandom_range(0, 15)), $urandom);
        end

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, '0, '0, 0, 0, 0, '0, '0);
        end
        checkOutput("q0_drained", exp_q0.size(), 0);
        checkOutput("q1_drained", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AWL, default 6, SHALL set data-memory address width.
REQ-002 Parameter DWL, default 32, SHALL set data-memory word width.
REQ-003 Parameter TMO, default 4, SHALL set lock-timeout in idle cycles, range 1..15.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 RST  in  1  SHALL be the synchronous, active-high reset.
REQ-006 REQn (n=0,1)  in  1  SHALL be the requester n access request.
REQ-007 WEn  in  1  SHALL mark a requester n access as a write (1) or read (0).
REQ-008 LOCKn  in  1  SHALL request ownership retention after the access.
REQ-009 ADDRn  in  AWL  SHALL be the requester n word address.
REQ-010 WDATAn  in  DWL  SHALL be the requester n write data.
REQ-011 GNTn  out  1  SHALL be the combinational grant; REQn&&GNTn is an accepted access.
REQ-012 RVALIDn  out  1  SHALL be the registered read-response strobe.
REQ-013 RDATAn  out  DWL  SHALL be the registered read data.
REQ-014 DMWE  out  1, DMWA  out  AWL, DMWD  out  DWL SHALL drive the memory write-enable, address, write data.
REQ-015 DMRD  in  DWL  SHALL be the memory's combinational read data for DMWA.

Function
REQ-016 States SHALL be IDLE, OWN0, OWN1; at most one access accepted per cycle.
REQ-017 IDLE: single requester SHALL be granted; both requesting -> grant requester indexed by PRI.
REQ-018 OWNn: only requester n SHALL be grantable; GNT of other requester held 0.
REQ-019 PRI SHALL point to the other requester after every accepted access.
REQ-020 Accepted access with LOCKn=1 SHALL transition to (or stay in) OWNn.
REQ-021 OWNn: accepted access with LOCKn=0 SHALL return to IDLE next cycle.
REQ-022 OWNn: 4-bit timer SHALL count cycles with REQn=0, clear on any accepted access, and force IDLE when it reaches TMO.
REQ-023 DMWE SHALL equal accepted&&WE of granted requester; DMWA/DMWD SHALL carry granted ADDR/WDATA, else all zero.
REQ-024 Accepted read SHALL assert RVALIDn for exactly one cycle, one cycle later, with RDATAn = DMRD sampled at acceptance.
REQ-025 RDATAn SHALL hold its value until the next read response to requester n.
REQ-026 Writes SHALL produce no response; write at cycle t SHALL be visible to any read accepted at t+1.
REQ-027 No GNT SHALL assert without the matching REQ; unrequested cycles drive DMWE=0.

Reset
REQ-028 RST=1 SHALL force state IDLE, PRI=0, timer=0, RVALID0/1=0, RDATA0/1=0 at next edge.
REQ-029 Reset during OWNn SHALL abandon the lock; an in-flight read response SHALL be dropped.
REQ-030 While RST=1, GNT0/1 and DMWE SHALL be 0.

Structure
REQ-031 Package dmem_arb_pkg SHALL hold the state encoding (IDLE/OWN0/OWN1) and AWL, DWL, TMO defaults.
REQ-032 Lock timer SHALL be a sub-module arb_lock_timer (clear, count-enable, TMO compare, expire flag).
REQ-033 Memory SHALL stay external; arbiter contains no storage array.

Verification
REQ-034 After reset, REQ0=REQ1=1 reads ADDR0=3, ADDR1=5 -> GNT0 cycle 1, GNT1 cycle 2, alternating; RVALID one cycle after each.
REQ-035 REQ1 write ADDR=7 WDATA=0xDEADBEEF, then REQ0 read ADDR=7 -> RDATA0=0xDEADBEEF, RVALID0 one cycle.
REQ-036 REQ0 LOCK0=1 read-modify-write ADDR=9 while REQ1=1 -> GNT1=0 until REQ0 write with LOCK0=0, then GNT1 next cycle.
REQ-037 OWN1 entered, REQ1 dropped, REQ0=1 -> GNT0 after exactly TMO=4 idle cycles.
REQ-038 RST asserted in OWN0 with read accepted -> next cycle IDLE, RVALID0=0, RDATA0=0, PRI=0.
